// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type, S-box table and GF(2^8) helpers.
// Imported by aes_round_comb and aes_round_iter.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES128_NR   = 10;
  localparam int AES192_NR   = 12;
  localparam int AES256_NR   = 14;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_e;

  // Entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_T[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// Combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when
// is_final), AddRoundKey. Ports: state, key, is_final -> next_state.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state,
  input  logic [AES_BLOCK_W-1:0] key,
  input  logic                   is_final,
  output logic [AES_BLOCK_W-1:0] next_state
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte i is row i%4, column i/4; byte 0 is the top byte of the bus.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = gf_mul(sr[4*c+0], 8'h02)
                ^ gf_mul(sr[4*c+1], 8'h03)
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c+0]
                ^ gf_mul(sr[4*c+1], 8'h02)
                ^ gf_mul(sr[4*c+2], 8'h03)
                ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1]
                ^ gf_mul(sr[4*c+2], 8'h02)
                ^ gf_mul(sr[4*c+3], 8'h03);
      mc[4*c+3] = gf_mul(sr[4*c+0], 8'h03)
                ^ sr[4*c+1] ^ sr[4*c+2]
                ^ gf_mul(sr[4*c+3], 8'h02);
    end
    next_state = '0;
    for (int i = 0; i < 16; i++) begin
      next_state[127-8*i -: 8] = (is_final ? sr[i] : mc[i])
                               ^ key[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_round_iter.sv
// Iterative AES encryptor, one round per cycle, keys fetched by index.
// Ports: clk, rst_n, i_Valid/o_Ready/i_Data in, o_Key_Idx/i_Key key
// fetch, o_Valid/i_Ready/o_Data out; i_Abort when AES_ROUND_ABORT_EN.
module aes_round_iter
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_IDX_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef AES_ROUND_ABORT_EN
  input  logic                   i_Abort,
`endif
  input  logic                   i_Valid,
  output logic                   o_Ready,
  input  logic [AES_BLOCK_W-1:0] i_Data,
  output logic [KEY_IDX_W-1:0]   o_Key_Idx,
  input  logic [AES_BLOCK_W-1:0] i_Key,
  output logic                   o_Valid,
  input  logic                   i_Ready,
  output logic [AES_BLOCK_W-1:0] o_Data
);

  if (NUM_ROUNDS != AES128_NR && NUM_ROUNDS != AES192_NR &&
      NUM_ROUNDS != AES256_NR) begin : g_bad_nr
    $error("aes_round_iter: NUM_ROUNDS must be 10, 12 or 14");
  end
  if ((1 << KEY_IDX_W) <= NUM_ROUNDS) begin : g_bad_kw
    $error("aes_round_iter: KEY_IDX_W too narrow for NUM_ROUNDS");
  end

  state_e                   st_q;
  logic [KEY_IDX_W-1:0]     cnt_q;
  logic [AES_BLOCK_W-1:0]   blk_q;
  logic                     vld_q;
  logic                     rdy_q;
  logic [AES_BLOCK_W-1:0]   rnd;
  logic                     last;
  logic                     abort;

`ifdef AES_ROUND_ABORT_EN
  assign abort = i_Abort;
`else
  assign abort = 1'b0;
`endif

  assign last = (cnt_q == KEY_IDX_W'(NUM_ROUNDS));

  aes_round_comb u_round (
    .state      (blk_q),
    .key        (i_Key),
    .is_final   (last),
    .next_state (rnd)
  );

  // The counter doubles as the key index: it is 0 in IDLE and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      blk_q <= '0;
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (i_Valid && rdy_q && !abort) begin
            blk_q <= i_Data ^ i_Key;
            cnt_q <= KEY_IDX_W'(1);
            rdy_q <= 1'b0;
            st_q  <= ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            blk_q <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b1;
            st_q  <= IDLE;
          end else begin
            blk_q <= rnd;
            if (last) begin
              cnt_q <= '0;
              vld_q <= 1'b1;
              st_q  <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (abort) begin
            blk_q <= '0;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            st_q  <= IDLE;
          end else if (i_Ready) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            st_q  <= IDLE;
          end
        end
        default: begin
          st_q  <= IDLE;
          cnt_q <= '0;
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_Ready   = rdy_q;
  assign o_Valid   = vld_q;
  assign o_Data    = blk_q;
  assign o_Key_Idx = cnt_q;

endmodule
